// File: rtl/riscv_core_csa_accumulator.sv
// riscv_core_csa_accumulator
//
// Iterative carry-save reduction stage that sits between the radix-16 Booth
// partial-product generator and the final carry-propagate adder. One partial
// product is absorbed per cycle over a valid/ready handshake. Each beat is
// folded into a redundant (sum, carry) pair through a WIDTH-wide row of 3:2
// full-adder cells. The pair is presented downstream once the last partial
// product has been absorbed.
//
// Optional feature macro: RISCV_CORE_CSA_RESOLVE_EN
//   defined   - an extra one-cycle RESOLVE state registers sum+carry into
//               o_res_product, which is valid together with o_res_valid.
//   undefined - no RESOLVE state; o_res_product is tied to 0 and the
//               downstream adder resolves the pair.
//
// Ports
//   i_clk, i_rst     clock (rising edge) and asynchronous active-high reset
//   i_flush          synchronous abort back to IDLE, beats that cycle ignored
//   i_pp_valid/o_pp_ready/i_pp_data/i_pp_last   partial-product input stream
//   o_res_valid/i_res_ready                     result handshake
//   o_res_sum, o_res_carry                      carry-save pair (carry pre-shifted)
//   o_res_product                               resolved product (macro only)
//   o_res_err        NUM_PP beats absorbed without i_pp_last
//   o_pp_count       beats accepted in the current operation
module riscv_core_csa_accumulator #(
  parameter int WIDTH  = 128,
  parameter int NUM_PP = 17,
  localparam int CW    = $clog2(NUM_PP + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_pp_valid,
  output logic             o_pp_ready,
  input  logic [WIDTH-1:0] i_pp_data,
  input  logic             i_pp_last,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic [WIDTH-1:0] o_res_sum,
  output logic [WIDTH-1:0] o_res_carry,
  output logic [WIDTH-1:0] o_res_product,
  output logic             o_res_err,
  output logic [CW-1:0]    o_pp_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    OUT     = 2'd3
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] carry;
  logic [CW-1:0]    count;
  logic             err;
  logic             res_valid;
  logic             pp_ready;

  logic             accept;
  logic [CW-1:0]    next_count;
  logic             done;
  logic             forced;

  // 3:2 compressor row: per-bit sum output.
  function automatic logic [WIDTH-1:0] csa_sum(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [WIDTH-1:0] c);
    return a ^ b ^ c;
  endfunction

  // 3:2 compressor row: majority carries moved one bit up. The carry out of
  // the top cell falls off, which is exactly mod-2^WIDTH arithmetic.
  function automatic logic [WIDTH-1:0] csa_carry(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic [WIDTH-1:0] c);
    logic [WIDTH-1:0] maj;
    maj = (a & b) | (a & c) | (b & c);
    return {maj[WIDTH-2:0], 1'b0};
  endfunction

  assign accept = i_pp_valid & pp_ready;

  // The beat being accepted this cycle becomes beat number next_count; the
  // operation ends on an explicit last, or is forced out at NUM_PP beats.
  always_comb begin
    next_count = (state == IDLE) ? CW'(1) : count + CW'(1);
    done       = i_pp_last || (next_count == CW'(NUM_PP));
    forced     = !i_pp_last && (next_count == CW'(NUM_PP));
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      sum       <= '0;
      carry     <= '0;
      count     <= '0;
      err       <= 1'b0;
      res_valid <= 1'b0;
      pp_ready  <= 1'b1;
    end else if (i_flush) begin
      state     <= IDLE;
      count     <= '0;
      err       <= 1'b0;
      res_valid <= 1'b0;
      pp_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            if (state == IDLE) begin
              sum   <= i_pp_data;
              carry <= '0;
            end else begin
              sum   <= csa_sum(sum, carry, i_pp_data);
              carry <= csa_carry(sum, carry, i_pp_data);
            end
            count <= next_count;
            err   <= forced;
            if (done) begin
              pp_ready <= 1'b0;
`ifdef RISCV_CORE_CSA_RESOLVE_EN
              state    <= RESOLVE;
`else
              state     <= OUT;
              res_valid <= 1'b1;
`endif
            end else begin
              state <= ACCUM;
            end
          end
        end
`ifdef RISCV_CORE_CSA_RESOLVE_EN
        RESOLVE: begin
          state     <= OUT;
          res_valid <= 1'b1;
        end
`endif
        OUT: begin
          if (i_res_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            pp_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          res_valid <= 1'b0;
          pp_ready  <= 1'b1;
        end
      endcase
    end
  end

`ifdef RISCV_CORE_CSA_RESOLVE_EN
  logic [WIDTH-1:0] product;

  // Final carry-propagate add, done once while passing through RESOLVE.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      product <= '0;
    end else if (state == RESOLVE) begin
      product <= sum + carry;
    end
  end

  assign o_res_product = product;
`else
  assign o_res_product = '0;
`endif

  assign o_pp_ready  = pp_ready;
  assign o_res_valid = res_valid;
  assign o_res_sum   = sum;
  assign o_res_carry = carry;
  assign o_res_err   = err;
  assign o_pp_count  = count;

endmodule

// File: tb/tb_riscv_core_csa_accumulator.sv
// Directed testbench for riscv_core_csa_accumulator at WIDTH=8, NUM_PP=4.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_riscv_core_csa_accumulator;

  localparam int WIDTH  = 8;
  localparam int NUM_PP = 4;
  localparam int CW     = $clog2(NUM_PP + 1);

  logic             clk;
  logic             rst;
  logic             flush;
  logic             pp_valid;
  logic             pp_ready;
  logic [WIDTH-1:0] pp_data;
  logic             pp_last;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_sum;
  logic [WIDTH-1:0] res_carry;
  logic [WIDTH-1:0] res_product;
  logic             res_err;
  logic [CW-1:0]    pp_count;

  int n_checks;
  int n_fail;

  logic [WIDTH-1:0] resolved;
  logic [WIDTH-1:0] exp_product;

  riscv_core_csa_accumulator #(.WIDTH(WIDTH), .NUM_PP(NUM_PP)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_flush      (flush),
    .i_pp_valid   (pp_valid),
    .o_pp_ready   (pp_ready),
    .i_pp_data    (pp_data),
    .i_pp_last    (pp_last),
    .o_res_valid  (res_valid),
    .i_res_ready  (res_ready),
    .o_res_sum    (res_sum),
    .o_res_carry  (res_carry),
    .o_res_product(res_product),
    .o_res_err    (res_err),
    .o_pp_count   (pp_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advances past the RESOLVE cycle when the macro build inserts one.
  task automatic resolve_gap();
`ifdef RISCV_CORE_CSA_RESOLVE_EN
    @(negedge clk);
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; pp_valid = 1'b0; pp_data = '0; pp_last = 1'b0; res_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", res_valid); end
    n_checks++; if (pp_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", pp_ready); end
    n_checks++; if (pp_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", pp_count); end
    n_checks++; if (res_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", res_err); end
    n_checks++; if (res_sum !== 8'h00 || res_carry !== 8'h00) begin n_fail++; $display("FAIL reset_pair: got %h/%h want 00/00", res_sum, res_carry); end
    rst = 1'b0;
  endtask

  task automatic test_single_beat();
    @(negedge clk);
    pp_valid = 1'b1; pp_data = 8'h5A; pp_last = 1'b1;
    @(negedge clk);
    pp_valid = 1'b0; pp_last = 1'b0;
`ifdef RISCV_CORE_CSA_RESOLVE_EN
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: got %b want 0", res_valid); end
`endif
    resolve_gap();
    n_checks++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL single_latency: got %b want 1", res_valid); end
    n_checks++; if (res_sum !== 8'h5A) begin n_fail++; $display("FAIL single_sum: got %h want 5a", res_sum); end
    n_checks++; if (res_carry !== 8'h00) begin n_fail++; $display("FAIL single_carry: got %h want 00", res_carry); end
    n_checks++; if (pp_count !== 3'd1) begin n_fail++; $display("FAIL single_count: got %0d want 1", pp_count); end
    n_checks++; if (res_err !== 1'b0) begin n_fail++; $display("FAIL single_err: got %b want 0", res_err); end
    n_checks++; if (pp_ready !== 1'b0) begin n_fail++; $display("FAIL single_ready_out: got %b want 0", pp_ready); end
    exp_product = 8'h00;
`ifdef RISCV_CORE_CSA_RESOLVE_EN
    exp_product = 8'h5A;
`endif
    n_checks++; if (res_product !== exp_product) begin n_fail++; $display("FAIL single_product: got %h want %h", res_product, exp_product); end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    n_checks++; if (res_valid !== 1'b0 || pp_ready !== 1'b1) begin n_fail++; $display("FAIL single_handshake: got valid=%b ready=%b want 0/1", res_valid, pp_ready); end
  endtask

  task automatic test_multi_beat();
    // 0F, then 01 -> sum 0E carry 02, then 01 -> sum 0D carry 04 (total 11).
    @(negedge clk); pp_valid = 1'b1; pp_data = 8'h0F; pp_last = 1'b0;
    @(negedge clk); pp_data = 8'h01;
    n_checks++; if (pp_count !== 3'd1) begin n_fail++; $display("FAIL multi_count1: got %0d want 1", pp_count); end
    @(negedge clk); pp_data = 8'h01; pp_last = 1'b1;
    n_checks++; if (res_sum !== 8'h0E || res_carry !== 8'h02) begin n_fail++; $display("FAIL multi_mid_pair: got %h/%h want 0e/02", res_sum, res_carry); end
    @(negedge clk); pp_valid = 1'b0; pp_last = 1'b0;
    resolve_gap();
    resolved = res_sum + res_carry;
    n_checks++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL multi_latency: got %b want 1", res_valid); end
    n_checks++; if (res_sum !== 8'h0D || res_carry !== 8'h04) begin n_fail++; $display("FAIL multi_pair: got %h/%h want 0d/04", res_sum, res_carry); end
    n_checks++; if (resolved !== 8'h11) begin n_fail++; $display("FAIL multi_total: got %h want 11", resolved); end
    n_checks++; if (pp_count !== 3'd3) begin n_fail++; $display("FAIL multi_count: got %0d want 3", pp_count); end
    exp_product = 8'h00;
`ifdef RISCV_CORE_CSA_RESOLVE_EN
    exp_product = 8'h11;
`endif
    n_checks++; if (res_product !== exp_product) begin n_fail++; $display("FAIL multi_product: got %h want %h", res_product, exp_product); end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_wrap();
    // FF then 02: sum FD, carry 04, total 101 -> 01 mod 256.
    @(negedge clk); pp_valid = 1'b1; pp_data = 8'hFF; pp_last = 1'b0;
    @(negedge clk); pp_data = 8'h02; pp_last = 1'b1;
    @(negedge clk); pp_valid = 1'b0; pp_last = 1'b0;
    resolve_gap();
    resolved = res_sum + res_carry;
    n_checks++; if (res_sum !== 8'hFD || res_carry !== 8'h04) begin n_fail++; $display("FAIL wrap_pair: got %h/%h want fd/04", res_sum, res_carry); end
    n_checks++; if (resolved !== 8'h01) begin n_fail++; $display("FAIL wrap_total: got %h want 01", resolved); end
    exp_product = 8'h00;
`ifdef RISCV_CORE_CSA_RESOLVE_EN
    exp_product = 8'h01;
`endif
    n_checks++; if (res_product !== exp_product) begin n_fail++; $display("FAIL wrap_product: got %h want %h", res_product, exp_product); end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  // Leaves the DUT parked in OUT with err set, for test_backpressure.
  task automatic test_forced_exit();
    // Four 01 beats: pairs 01/00, 00/02, 03/00, 02/02 -> total 04.
    @(negedge clk); pp_valid = 1'b1; pp_data = 8'h01; pp_last = 1'b0;
    repeat (4) @(negedge clk);
    // A fifth beat stays offered; it must not be taken while in OUT.
    resolve_gap();
    resolved = res_sum + res_carry;
    n_checks++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL forced_valid: got %b want 1", res_valid); end
    n_checks++; if (res_err !== 1'b1) begin n_fail++; $display("FAIL forced_err: got %b want 1", res_err); end
    n_checks++; if (res_sum !== 8'h02 || res_carry !== 8'h02) begin n_fail++; $display("FAIL forced_pair: got %h/%h want 02/02", res_sum, res_carry); end
    n_checks++; if (resolved !== 8'h04) begin n_fail++; $display("FAIL forced_total: got %h want 04", resolved); end
    n_checks++; if (pp_count !== 3'd4) begin n_fail++; $display("FAIL forced_count: got %0d want 4", pp_count); end
    n_checks++; if (pp_ready !== 1'b0) begin n_fail++; $display("FAIL forced_ready: got %b want 0", pp_ready); end
    pp_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (res_valid !== 1'b1 || pp_ready !== 1'b0 || res_sum !== 8'h02 || res_carry !== 8'h02 || pp_count !== 3'd4 || res_err !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got v=%b r=%b s=%h c=%h n=%0d e=%b want 1/0/02/02/4/1", i, res_valid, pp_ready, res_sum, res_carry, pp_count, res_err);
      end
    end
    // Handshake with a new beat already offered: it is not taken in OUT.
    res_ready = 1'b1; pp_valid = 1'b1; pp_data = 8'hA5; pp_last = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    n_checks++; if (res_valid !== 1'b0 || pp_ready !== 1'b1) begin n_fail++; $display("FAIL bp_handshake: got v=%b r=%b want 0/1", res_valid, pp_ready); end
    n_checks++; if (res_sum !== 8'h02) begin n_fail++; $display("FAIL bp_no_turnaround: got %h want 02", res_sum); end
    @(negedge clk);
    pp_valid = 1'b0; pp_last = 1'b0;
    n_checks++; if (res_err !== 1'b0) begin n_fail++; $display("FAIL bp_err_clear: got %b want 0", res_err); end
    n_checks++; if (res_sum !== 8'hA5 || pp_count !== 3'd1) begin n_fail++; $display("FAIL bp_next_accept: got %h/%0d want a5/1", res_sum, pp_count); end
    resolve_gap();
    n_checks++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL bp_next_valid: got %b want 1", res_valid); end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_flush();
    @(negedge clk); pp_valid = 1'b1; pp_data = 8'h01; pp_last = 1'b0;
    @(negedge clk); pp_data = 8'h02;
    @(negedge clk); flush = 1'b1; pp_data = 8'h04; pp_last = 1'b1;
    n_checks++; if (pp_count !== 3'd2) begin n_fail++; $display("FAIL flush_pre_count: got %0d want 2", pp_count); end
    @(negedge clk); flush = 1'b0; pp_valid = 1'b0; pp_last = 1'b0;
    n_checks++; if (pp_count !== 3'd0 || res_valid !== 1'b0 || res_err !== 1'b0 || pp_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_idle: got n=%0d v=%b e=%b r=%b want 0/0/0/1", pp_count, res_valid, res_err, pp_ready);
    end
    pp_valid = 1'b1; pp_data = 8'h33; pp_last = 1'b1;
    @(negedge clk); pp_valid = 1'b0; pp_last = 1'b0;
    resolve_gap();
    resolved = res_sum + res_carry;
    n_checks++; if (res_valid !== 1'b1 || resolved !== 8'h33 || pp_count !== 3'd1) begin
      n_fail++; $display("FAIL flush_next_op: got v=%b total=%h n=%0d want 1/33/1", res_valid, resolved, pp_count);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_rst_mid();
    @(negedge clk); pp_valid = 1'b1; pp_data = 8'h01; pp_last = 1'b0;
    @(negedge clk);
    @(negedge clk); pp_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_checks++; if (pp_count !== 3'd0 || res_valid !== 1'b0 || res_sum !== 8'h00 || res_carry !== 8'h00 || pp_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid: got n=%0d v=%b s=%h c=%h r=%b want 0/0/00/00/1", pp_count, res_valid, res_sum, res_carry, pp_ready);
    end
    @(negedge clk); rst = 1'b0;
    pp_valid = 1'b1; pp_data = 8'h33; pp_last = 1'b1;
    @(negedge clk); pp_valid = 1'b0; pp_last = 1'b0;
    resolve_gap();
    resolved = res_sum + res_carry;
    n_checks++; if (res_valid !== 1'b1 || resolved !== 8'h33) begin n_fail++; $display("FAIL rst_next_op: got v=%b total=%h want 1/33", res_valid, resolved); end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single_beat();
    test_multi_beat();
    test_wrap();
    test_forced_exit();
    test_backpressure();
    test_flush();
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
